// File: rtl/multicycle_ctrl_pkg.sv
// Shared MIPS control definitions: opcode/funct encodings, ALU operation
// codes, datapath mux select encodings and the controller state encoding.
package multicycle_ctrl_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Memory address select
  localparam logic IORD_PC     = 1'b0;
  localparam logic IORD_ALUOUT = 1'b1;

  // Register destination select
  localparam logic REGDST_RT = 1'b0;
  localparam logic REGDST_RD = 1'b1;

  // ALU operand selects
  localparam logic       SRCA_PC    = 1'b0;
  localparam logic       SRCA_A     = 1'b1;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Controller states; encodings 12-15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // What kind of ALU operation the current state asks for
  typedef enum logic [2:0] {
    ALU_CLS_NONE  = 3'd0,
    ALU_CLS_ADD   = 3'd1,
    ALU_CLS_SUB   = 3'd2,
    ALU_CLS_FUNCT = 3'd3,
    ALU_CLS_IMM   = 3'd4
  } alu_cls_t;

  // True for every opcode the controller knows how to sequence
  function automatic logic opcode_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU control decoder: maps the state's ALU request class plus the
// instruction's opcode/funct to an ALU operation code, and flags whether
// the funct field is a supported R-type operation.
module multicycle_ctrl_alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  alu_cls_t   cls,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_valid
);

  logic [2:0] funct_alu;

  // Decode the R-type funct field independently of the requesting state
  always_comb begin
    funct_valid = 1'b1;
    funct_alu   = ALU_ADD;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

  // Select the final ALU operation from the request class
  always_comb begin
    alu_ctrl = ALU_AND;
    case (cls)
      ALU_CLS_ADD:   alu_ctrl = ALU_ADD;
      ALU_CLS_SUB:   alu_ctrl = ALU_SUB;
      ALU_CLS_FUNCT: alu_ctrl = funct_alu;
      ALU_CLS_IMM:   alu_ctrl = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
      default:       alu_ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core. Sequences fetch, decode,
// execute, memory and writeback steps, drives the datapath enables and mux
// selects from the current state, and counts retired instructions.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             imm_zext,
  output logic [2:0]       alu_ctrl,
  output logic [1:0]       pc_src,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t   st;
  alu_cls_t alu_cls;
  logic     funct_valid;

  // Raw state decodes before the reset gate on the write enables
  logic     pc_write;
  logic     branch;
  logic     mem_write_raw;
  logic     ir_write_raw;
  logic     reg_write_raw;

  multicycle_ctrl_alu_decoder u_alu_decoder (
    .cls         (alu_cls),
    .opcode      (opcode),
    .funct       (funct),
    .alu_ctrl    (alu_ctrl),
    .funct_valid (funct_valid)
  );

  // State register and transitions; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= S_FETCH;
    end else begin
      case (st)
        S_FETCH:  if (run) st <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW:    st <= S_MEMADR;
            OP_RTYPE:        st <= S_EXEC;
            OP_BEQ:          st <= S_BRANCH;
            OP_ADDI, OP_ORI: st <= S_IEXEC;
            OP_J:            st <= S_JUMP;
            default:         st <= S_FETCH;
          endcase
        end
        S_MEMADR: st <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  st <= S_MEMWB;
        S_EXEC:   st <= funct_valid ? S_ALUWB : S_FETCH;
        S_IEXEC:  st <= S_IWB;
        // Final states of every instruction and unused encodings
        default:  st <= S_FETCH;
      endcase
    end
  end

  // Moore output decode; only FETCH looks at run, only DECODE/EXEC flag illegal
  always_comb begin
    pc_write      = 1'b0;
    branch        = 1'b0;
    iord          = IORD_PC;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_dst       = REGDST_RT;
    mem_to_reg    = 1'b0;
    reg_write_raw = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_B;
    imm_zext      = 1'b0;
    alu_cls       = ALU_CLS_NONE;
    pc_src        = PCSRC_ALU;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    case (st)
      S_FETCH: begin
        if (run) begin
          ir_write_raw = 1'b1;
          pc_write     = 1'b1;
          alu_src_b    = SRCB_FOUR;
          alu_cls      = ALU_CLS_ADD;
        end
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut
        alu_src_b = SRCB_BRIMM;
        alu_cls   = ALU_CLS_ADD;
        illegal   = !opcode_supported(opcode);
      end
      S_MEMADR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        alu_cls   = ALU_CLS_ADD;
      end
      S_MEMRD: begin
        iord = IORD_ALUOUT;
      end
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
        reg_dst       = REGDST_RT;
        instr_done    = 1'b1;
      end
      S_MEMWR: begin
        iord          = IORD_ALUOUT;
        mem_write_raw = 1'b1;
        instr_done    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_B;
        alu_cls   = ALU_CLS_FUNCT;
        illegal   = !funct_valid;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        reg_dst       = REGDST_RD;
        instr_done    = 1'b1;
      end
      S_BRANCH: begin
        // Counts as done whether or not the branch is taken
        alu_src_a  = SRCA_A;
        alu_src_b  = SRCB_B;
        alu_cls    = ALU_CLS_SUB;
        pc_src     = PCSRC_ALUOUT;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        alu_cls   = ALU_CLS_IMM;
        imm_zext  = (opcode == OP_ORI);
      end
      S_IWB: begin
        reg_write_raw = 1'b1;
        reg_dst       = REGDST_RT;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Architectural write enables are held off while reset is asserted
  assign pc_en     = reset_n & (pc_write | (branch & zero));
  assign ir_write  = reset_n & ir_write_raw;
  assign mem_write = reset_n & mem_write_raw;
  assign reg_write = reset_n & reg_write_raw;
  assign state     = st;

  // Retired-instruction counter, bumped on the final cycle of each legal instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired <= '0;
    end else if (instr_done) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule
